load_scoreboard_hdu: RTL and testbench

- Hazard/issue controller for the ID stage; produces the ID stage's stall/flush control and the EX bubble-insert strobe.
- Tracks outstanding long-latency loads in a per-register scoreboard and stalls dependent instructions (RAW and WAW) until the LSU returns data.
- Serialises CSR writes by draining the pipeline.
- Converts an EX-stage branch/jump mispredict into an IF/ID flush.

---
 rtl/hdu_pkg.sv | 16 +
 rtl/id_stage_pkg.sv | 9 +
 rtl/reg_scoreboard.sv | 63 ++++++
 rtl/load_scoreboard_hdu.sv | 112 +++++++++++
 tb/tb_load_scoreboard_hdu.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdu_pkg.sv
// Hazard-unit shared types, widths and helpers.
package hdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        RUN       = 1'b0,
        CSR_DRAIN = 1'b1
    } hdu_state_e;

    // Scoreboard lookup; bit 0 is kept at zero by the scoreboard itself.
    function automatic logic sb_hit_f(input logic [31:0] sb, input logic [4:0] idx);
        return sb[idx];
    endfunction

endpackage

// File: rtl/id_stage_pkg.sv
// ID-stage shared types: control bundle driven into the IF/ID registers.
package id_stage_pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } id_hdu_out_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-load vector, in-flight load count and sticky
// protocol-error flag for unexpected LSU responses.
module reg_scoreboard
    import hdu_pkg::*;
(
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load_fire,
    input  logic             load_rf_en,
    input  logic [4:0]       load_rd,
    input  logic             resp_valid,
    input  logic [4:0]       resp_rd,
    output logic [31:0]      sb,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    logic [31:0]      sb_d;
    logic [CNT_W-1:0] count_d;
    logic             resp_bad;
    logic             resp_ok;

    // Classify the response: unexpected ones are flagged and otherwise ignored.
    always_comb begin
        resp_bad = resp_valid & ((count == '0) | ((resp_rd != 5'd0) & ~sb_hit_f(sb, resp_rd)));
        resp_ok  = resp_valid & ~resp_bad;
    end

    // Next-state for the pending vector and count.
    // NOTE: every variable gets its default first so always_comb never infers a latch.
    always_comb begin
        sb_d    = sb;
        count_d = count;
        if (load_fire && load_rf_en && (load_rd != 5'd0)) begin
            sb_d[load_rd] = 1'b1;
        end
        if (resp_ok && (resp_rd != 5'd0)) begin
            sb_d[resp_rd] = 1'b0;
        end
        sb_d[0] = 1'b0;
        unique case ({load_fire, resp_ok})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // State registers.
    // NOTE: the 32-entry vector is flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            sb    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            sb    <= sb_d;
            count <= count_d;
            err   <= err | resp_bad;
        end
    end

endmodule

// File: rtl/load_scoreboard_hdu.sv
// ID-stage hazard/issue controller: load-use and WAW stalls against
// outstanding loads, CSR-write pipeline drain and mispredict flush.
module load_scoreboard_hdu
    import hdu_pkg::*;
    import id_stage_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DRAIN_CYCLES    = 3
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        id_rf_en_i,
    input  logic        id_dm_rd_en_i,
    input  logic        id_csr_wr_en_i,
    input  logic        ex_mispredict_i,
    input  logic        lsu_resp_valid_i,
    input  logic [4:0]  lsu_resp_rd_i,
    output id_hdu_out_t hdu_o,
    output logic        ex_bubble_o,
    output logic [31:0] pending_o,
    output logic [3:0]  outstanding_o,
    output logic        sb_err_o
);

    hdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic [31:0]      sb;
    logic [CNT_W-1:0] count;
    logic             sb_err;
    logic             raw, waw, full, csr_wait;
    logic             stall_c, flush, stall, fire;

    reg_scoreboard u_sb (
        .clk        (clk),
        .arst_n     (arst_n),
        .load_fire  (fire & id_dm_rd_en_i),
        .load_rf_en (id_rf_en_i),
        .load_rd    (id_rd_i),
        .resp_valid (lsu_resp_valid_i),
        .resp_rd    (lsu_resp_rd_i),
        .sb         (sb),
        .count      (count),
        .err        (sb_err)
    );

    // Hazard equations against registered scoreboard state (no response bypass).
    always_comb begin
        raw      = (id_uses_rs1_i & sb_hit_f(sb, id_rs1_i))
                 | (id_uses_rs2_i & sb_hit_f(sb, id_rs2_i));
        waw      = id_rf_en_i & (id_rd_i != 5'd0) & sb_hit_f(sb, id_rd_i);
        full     = id_dm_rd_en_i & (count == CNT_W'(MAX_OUTSTANDING));
        csr_wait = id_csr_wr_en_i & (count != '0);
        stall_c  = (id_valid_i & (raw | waw | full | csr_wait)) | (state_q == CSR_DRAIN);
        flush    = ex_mispredict_i;
        stall    = stall_c & ~flush;
        fire     = id_valid_i & ~stall_c & ~flush;
    end

    // Drain FSM next-state: a fired CSR write holds ID for DRAIN_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (fire && id_csr_wr_en_i) begin
                    state_d = CSR_DRAIN;
                    drain_d = CNT_W'(DRAIN_CYCLES);
                end
            end
            CSR_DRAIN: begin
                if (flush || (drain_q == CNT_W'(1))) begin
                    state_d = RUN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                drain_d = '0;
            end
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Outputs; combinational controls are masked so reset silences them at once.
    always_comb begin
        hdu_o.stall   = stall & arst_n;
        hdu_o.flush   = flush & arst_n;
        ex_bubble_o   = (stall | flush) & arst_n;
        pending_o     = sb;
        outstanding_o = count;
        sb_err_o      = sb_err;
    end

endmodule

// File: tb/tb_load_scoreboard_hdu.sv
// Directed self-checking bench for load_scoreboard_hdu.
module tb_load_scoreboard_hdu;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_uses_rs1_i, id_uses_rs2_i, id_rf_en_i;
    logic        id_dm_rd_en_i, id_csr_wr_en_i;
    logic        ex_mispredict_i;
    logic        lsu_resp_valid_i;
    logic [4:0]  lsu_resp_rd_i;
    id_hdu_out_t hdu_o;
    logic        ex_bubble_o;
    logic [31:0] pending_o;
    logic [3:0]  outstanding_o;
    logic        sb_err_o;

    int checks   = 0;
    int failures = 0;

    load_scoreboard_hdu #(.MAX_OUTSTANDING(4), .DRAIN_CYCLES(3)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .id_valid_i       (id_valid_i),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .id_rd_i          (id_rd_i),
        .id_uses_rs1_i    (id_uses_rs1_i),
        .id_uses_rs2_i    (id_uses_rs2_i),
        .id_rf_en_i       (id_rf_en_i),
        .id_dm_rd_en_i    (id_dm_rd_en_i),
        .id_csr_wr_en_i   (id_csr_wr_en_i),
        .ex_mispredict_i  (ex_mispredict_i),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_resp_rd_i    (lsu_resp_rd_i),
        .hdu_o            (hdu_o),
        .ex_bubble_o      (ex_bubble_o),
        .pending_o        (pending_o),
        .outstanding_o    (outstanding_o),
        .sb_err_o         (sb_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        id_valid_i      = 1'b0;
        id_rs1_i        = 5'd0;
        id_rs2_i        = 5'd0;
        id_rd_i         = 5'd0;
        id_uses_rs1_i   = 1'b0;
        id_uses_rs2_i   = 1'b0;
        id_rf_en_i      = 1'b0;
        id_dm_rd_en_i   = 1'b0;
        id_csr_wr_en_i  = 1'b0;
        ex_mispredict_i = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        clear_in();
        id_valid_i    = 1'b1;
        id_rd_i       = rd;
        id_rf_en_i    = 1'b1;
        id_dm_rd_en_i = 1'b1;
    endtask

    task automatic drive_alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        clear_in();
        id_valid_i    = 1'b1;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_rd_i       = rd;
        id_uses_rs1_i = 1'b1;
        id_uses_rs2_i = 1'b1;
        id_rf_en_i    = 1'b1;
    endtask

    task automatic resp(input logic v, input logic [4:0] rd);
        lsu_resp_valid_i = v;
        lsu_resp_rd_i    = rd;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        arst_n = 1'b0;
        clear_in();
        resp(1'b0, 5'd0);
        // Reset: even with a mispredict and a valid instruction, outputs stay 0.
        ex_mispredict_i = 1'b1;
        id_valid_i      = 1'b1;
        #3;
        check("rst_hdu", {30'd0, hdu_o}, 32'h0);
        check("rst_bubble", {31'd0, ex_bubble_o}, 32'h0);
        check("rst_pending", pending_o, 32'h0);
        check("rst_outstanding", {28'd0, outstanding_o}, 32'h0);
        check("rst_err", {31'd0, sb_err_o}, 32'h0);
        clear_in();
        @(negedge clk);
        arst_n = 1'b1;
        advance();

        // Load-use: load x5, dependent add stalls until one cycle after the response.
        drive_load(5'd5);
        @(negedge clk);
        check("t1_load_stall", {31'd0, hdu_o.stall}, 32'h0);
        advance();
        drive_alu(5'd5, 5'd0, 5'd8);
        @(negedge clk);
        check("t1_raw_stall", {31'd0, hdu_o.stall}, 32'h1);
        check("t1_raw_bubble", {31'd0, ex_bubble_o}, 32'h1);
        check("t1_pending", pending_o, 32'h0000_0020);
        check("t1_outstanding", {28'd0, outstanding_o}, 32'h1);
        advance();
        resp(1'b1, 5'd5);
        @(negedge clk);
        check("t1_no_bypass", {31'd0, hdu_o.stall}, 32'h1);
        advance();
        resp(1'b0, 5'd0);
        @(negedge clk);
        check("t1_release", {31'd0, hdu_o.stall}, 32'h0);
        check("t1_pending_clr", pending_o, 32'h0);
        advance();

        // Four loads in flight, fifth load stalls on full count.
        for (int i = 1; i <= 4; i++) begin
            drive_load(5'(i));
            advance();
        end
        drive_load(5'd6);
        @(negedge clk);
        check("t2_outstanding", {28'd0, outstanding_o}, 32'h4);
        check("t2_pending", pending_o, 32'h0000_001E);
        check("t2_full_stall", {31'd0, hdu_o.stall}, 32'h1);
        advance();
        resp(1'b1, 5'd2);
        @(negedge clk);
        check("t2_full_still", {31'd0, hdu_o.stall}, 32'h1);
        advance();
        resp(1'b0, 5'd0);
        @(negedge clk);
        check("t2_fire", {31'd0, hdu_o.stall}, 32'h0);
        advance();
        clear_in();
        @(negedge clk);
        check("t2_pending_after", pending_o, 32'h0000_005A);
        check("t2_count_after", {28'd0, outstanding_o}, 32'h4);

        // Mispredict during a RAW stall: flush wins, scoreboard untouched.
        drive_alu(5'd6, 5'd0, 5'd9);
        ex_mispredict_i = 1'b1;
        #1;
        check("t3_hdu", {30'd0, hdu_o}, 32'h1);
        check("t3_bubble", {31'd0, ex_bubble_o}, 32'h1);
        advance();
        clear_in();
        @(negedge clk);
        check("t3_pending", pending_o, 32'h0000_005A);
        check("t3_count", {28'd0, outstanding_o}, 32'h4);
        foreach (pending_o[i]) begin
            if (i == 1 || i == 3 || i == 4 || i == 6) begin
                resp(1'b1, 5'(i));
                advance();
            end
        end
        resp(1'b0, 5'd0);
        @(negedge clk);
        check("t3_drained", {28'd0, outstanding_o}, 32'h0);
        check("t3_err_clean", {31'd0, sb_err_o}, 32'h0);

        // CSR write waits for outstanding loads, then drains for 3 cycles.
        drive_load(5'd9);
        advance();
        drive_load(5'd10);
        advance();
        clear_in();
        id_valid_i     = 1'b1;
        id_csr_wr_en_i = 1'b1;
        @(negedge clk);
        check("t4_csr_wait", {31'd0, hdu_o.stall}, 32'h1);
        check("t4_count2", {28'd0, outstanding_o}, 32'h2);
        advance();
        resp(1'b1, 5'd9);
        @(negedge clk);
        check("t4_wait_a", {31'd0, hdu_o.stall}, 32'h1);
        advance();
        resp(1'b1, 5'd10);
        @(negedge clk);
        check("t4_wait_b", {31'd0, hdu_o.stall}, 32'h1);
        advance();
        resp(1'b0, 5'd0);
        @(negedge clk);
        check("t4_csr_fire", {31'd0, hdu_o.stall}, 32'h0);
        advance();
        drive_alu(5'd1, 5'd2, 5'd12);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("t4_drain%0d", c), {31'd0, hdu_o.stall}, 32'h1);
            advance();
        end
        @(negedge clk);
        check("t4_run", {31'd0, hdu_o.stall}, 32'h0);
        advance();

        // Simultaneous load issue and response; then an unexpected response.
        drive_load(5'd3);
        advance();
        drive_load(5'd7);
        resp(1'b1, 5'd3);
        @(negedge clk);
        check("t5_issue", {31'd0, hdu_o.stall}, 32'h0);
        advance();
        clear_in();
        resp(1'b0, 5'd0);
        @(negedge clk);
        check("t5_count", {28'd0, outstanding_o}, 32'h1);
        check("t5_pending", pending_o, 32'h0000_0080);
        resp(1'b1, 5'd7);
        advance();
        @(negedge clk);
        check("t5_err_pre", {31'd0, sb_err_o}, 32'h0);
        advance();
        resp(1'b0, 5'd0);
        @(negedge clk);
        check("t5_err", {31'd0, sb_err_o}, 32'h1);
        check("t5_count0", {28'd0, outstanding_o}, 32'h0);
        check("t5_pending0", pending_o, 32'h0);

        // Asynchronous reset in the middle of a drain with a load pending.
        clear_in();
        id_valid_i     = 1'b1;
        id_csr_wr_en_i = 1'b1;
        id_dm_rd_en_i  = 1'b1;
        id_rf_en_i     = 1'b1;
        id_rd_i        = 5'd1;
        advance();
        drive_alu(5'd1, 5'd0, 5'd13);
        @(negedge clk);
        check("t6_pre_stall", {31'd0, hdu_o.stall}, 32'h1);
        check("t6_pre_pending", pending_o, 32'h0000_0002);
        ex_mispredict_i = 1'b1;
        #1;
        arst_n = 1'b0;
        #1;
        check("t6_hdu", {30'd0, hdu_o}, 32'h0);
        check("t6_bubble", {31'd0, ex_bubble_o}, 32'h0);
        check("t6_pending", pending_o, 32'h0);
        check("t6_count", {28'd0, outstanding_o}, 32'h0);
        check("t6_err", {31'd0, sb_err_o}, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        drive_alu(5'd1, 5'd0, 5'd13);
        #1;
        check("t6_run_stall", {31'd0, hdu_o.stall}, 32'h0);
        advance();
        @(negedge clk);
        check("t6_run_stall2", {31'd0, hdu_o.stall}, 32'h0);
        check("t6_pending_post", pending_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
